// File: rtl/fir_seq_mac.sv
// fir_seq_mac: time-multiplexed fixed-point FIR filter.
// One signed multiply-accumulate per cycle walks a circular history buffer
// against a loadable coefficient bank. The runtime tap count is latched when
// a sample is accepted. The result is rounded, arithmetically shifted right
// by SHIFT and saturated to DW bits.
//
// Ports:
//   clk, rst_n            clock (posedge) and asynchronous active-low reset
//   din/din_valid/din_ready   input sample handshake (accepted only in IDLE)
//   ntaps                 active taps; 0 or >TAPS selects TAPS
//   cin/caddr/cload       coefficient write port (honoured in IDLE and OUT)
//   flush                 clears the history buffer (honoured in IDLE only)
//   dout/dout_valid/dout_ready  output handshake; dout holds after transfer
//   busy                  high whenever the block is not IDLE
module fir_seq_mac #(
  parameter int DW    = 16,
  parameter int CW    = 17,
  parameter int TAPS  = 64,
  parameter int AW    = $clog2(TAPS),
  parameter int ACCW  = DW + CW + AW,
  parameter int SHIFT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic signed [DW-1:0] din,
  input  logic                 din_valid,
  output logic                 din_ready,
  input  logic [AW:0]          ntaps,
  input  logic signed [CW-1:0] cin,
  input  logic [AW-1:0]        caddr,
  input  logic                 cload,
  input  logic                 flush,
  output logic signed [DW-1:0] dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 busy
);

  typedef enum logic [2:0] {
    CLR_ALL,
    CLR_HIST,
    IDLE,
    MAC,
    OUT
  } state_t;

  localparam logic [AW:0]          TAPS_N   = (AW+1)'(TAPS);
  localparam logic [AW-1:0]        LAST     = AW'(TAPS - 1);
  localparam logic [ACCW:0]        BIAS     = ((ACCW+1)'(1) << SHIFT) >> 1;
  localparam logic signed [ACCW:0] MAXV     = {{(ACCW+2-DW){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW:0] MINV     = {{(ACCW+2-DW){1'b1}}, {(DW-1){1'b0}}};
  localparam logic signed [DW-1:0] DOUT_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] DOUT_MIN = {1'b1, {(DW-1){1'b0}}};

  state_t state, state_nxt;

  logic [AW-1:0]          cnt;
  logic [AW-1:0]          wptr;
  logic [AW-1:0]          rptr;
  logic [AW-1:0]          k;
  logic [AW:0]            n;
  logic signed [ACCW-1:0] acc;

  logic signed [DW-1:0]   hist [TAPS];
  logic signed [CW-1:0]   coef [TAPS];

  logic                   accept;
  logic                   clr_done;
  logic                   mac_last;
  logic                   coef_we;
  logic [AW:0]            n_eff;

  logic signed [DW+CW-1:0] prod;
  logic signed [ACCW-1:0]  acc_sum;
  logic signed [ACCW:0]    rnd;
  logic signed [ACCW:0]    shv;
  logic signed [DW-1:0]    sat_val;

  // ---------------------------------------------------------------- control
  always_comb begin
    accept   = (state == IDLE) && din_valid && !flush;
    clr_done = (cnt == LAST);
    mac_last = ({1'b0, k} == (n - (AW+1)'(1)));
    coef_we  = ((state == IDLE) || (state == OUT)) && cload && ({1'b0, caddr} < TAPS_N);
    n_eff    = ((ntaps == '0) || (ntaps > TAPS_N)) ? TAPS_N : ntaps;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= CLR_ALL;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    din_ready  = 1'b0;
    busy       = 1'b1;
    dout_valid = 1'b0;
    case (state)
      CLR_ALL, CLR_HIST: begin
        if (clr_done) state_nxt = IDLE;
      end
      IDLE: begin
        din_ready = 1'b1;
        busy      = 1'b0;
        // flush takes priority over a simultaneous sample
        if (flush)          state_nxt = CLR_HIST;
        else if (din_valid) state_nxt = MAC;
      end
      MAC: begin
        if (mac_last) state_nxt = OUT;
      end
      OUT: begin
        dout_valid = 1'b1;
        if (dout_ready) state_nxt = IDLE;
      end
      default: state_nxt = CLR_ALL;
    endcase
  end

  // --------------------------------------------------------------- datapath
  always_comb begin
    prod    = (DW+CW)'(coef[k]) * (DW+CW)'(hist[rptr]);
    acc_sum = acc + {{AW{prod[DW+CW-1]}}, prod};
    rnd     = {acc_sum[ACCW-1], acc_sum} + BIAS;
    shv     = rnd >>> SHIFT;
    if (shv > MAXV)      sat_val = DOUT_MAX;
    else if (shv < MINV) sat_val = DOUT_MIN;
    else                 sat_val = shv[DW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      wptr <= '0;
      rptr <= '0;
      k    <= '0;
      n    <= '0;
      acc  <= '0;
      dout <= '0;
    end else begin
      case (state)
        CLR_ALL, CLR_HIST: begin
          cnt  <= clr_done ? '0 : cnt + AW'(1);
          wptr <= '0;
        end
        IDLE: begin
          if (accept) begin
            n    <= n_eff;
            acc  <= '0;
            k    <= '0;
            rptr <= wptr;
          end
        end
        MAC: begin
          acc  <= acc_sum;
          k    <= k + AW'(1);
          // walk backwards through history, wrapping at TAPS (any size)
          rptr <= (rptr == '0) ? LAST : rptr - AW'(1);
          if (mac_last) begin
            wptr <= (wptr == LAST) ? '0 : wptr + AW'(1);
            dout <= sat_val;
          end
        end
        default: ;
      endcase
    end
  end

  // Storage is cleared by the CLR states rather than by reset.
  always_ff @(posedge clk) begin
    case (state)
      CLR_ALL: begin
        hist[cnt] <= '0;
        coef[cnt] <= '0;
      end
      CLR_HIST: begin
        hist[cnt] <= '0;
      end
      default: begin
        if (accept)  hist[wptr]  <= din;
        if (coef_we) coef[caddr] <= cin;
      end
    endcase
  end

endmodule

// File: tb/tb_fir_seq_mac.sv
module tb_fir_seq_mac;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [2:0][15:0] din;
  logic [2:0]       din_valid;
  wire  [2:0]       din_ready;
  logic [2:0][8:0]  ntaps;
  logic [2:0][16:0] cin;
  logic [2:0][7:0]  caddr;
  logic [2:0]       cload;
  logic [2:0]       flush;
  wire  [2:0][15:0] dout;
  wire  [2:0]       dout_valid;
  logic [2:0]       dout_ready;
  wire  [2:0]       busy;

  // instance 0: TAPS=64 SHIFT=0, instance 1: TAPS=64 SHIFT=15, instance 2: TAPS=5 SHIFT=0
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int TG  = (g == 2) ? 5 : 64;
    localparam int SG  = (g == 1) ? 15 : 0;
    localparam int AWG = $clog2(TG);
    fir_seq_mac #(.DW(16), .CW(17), .TAPS(TG), .SHIFT(SG)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .din        (din[g]),
      .din_valid  (din_valid[g]),
      .din_ready  (din_ready[g]),
      .ntaps      (ntaps[g][AWG:0]),
      .cin        (cin[g]),
      .caddr      (caddr[g][AWG-1:0]),
      .cload      (cload[g]),
      .flush      (flush[g]),
      .dout       (dout[g]),
      .dout_valid (dout_valid[g]),
      .dout_ready (dout_ready[g]),
      .busy       (busy[g])
    );
  end

  int vectors     = 0;
  int miscompares = 0;

  // reference model: coefficient bank and "sample k ago" history per instance
  longint coef_m [3][64];
  longint hist_m [3][64];

  function automatic int taps_of(input int unsigned g);
    return (g == 2) ? 5 : 64;
  endfunction

  function automatic int sh_of(input int unsigned g);
    return (g == 1) ? 15 : 0;
  endfunction

  function automatic int neff(input int unsigned g, input int unsigned nt);
    if (nt == 0 || nt > taps_of(g)) return taps_of(g);
    return int'(nt);
  endfunction

  function automatic longint model_y(input int unsigned g, input int n);
    longint s = 0;
    for (int k = 0; k < n; k++) s += coef_m[g][k] * hist_m[g][k];
    if (sh_of(g) > 0) s = s + (longint'(1) <<< (sh_of(g) - 1));
    s = s >>> sh_of(g);
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    return s;
  endfunction

  function automatic void model_reset();
    for (int unsigned g = 0; g < 3; g++)
      for (int unsigned k = 0; k < 64; k++) begin
        coef_m[g][k] = 0;
        hist_m[g][k] = 0;
      end
  endfunction

  function automatic void model_clear_hist(input int unsigned g);
    for (int unsigned k = 0; k < 64; k++) hist_m[g][k] = 0;
  endfunction

  function automatic void model_push(input int unsigned g, input logic [15:0] x);
    for (int unsigned k = 63; k > 0; k--) hist_m[g][k] = hist_m[g][k-1];
    hist_m[g][0] = longint'($signed(x));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_coef(input int unsigned g, input int unsigned a, input logic [16:0] v);
    cin[g]   = v;
    caddr[g] = 8'(a);
    cload[g] = 1'b1;
    tick();
    cload[g] = 1'b0;
    if (a < 64 && int'(a) < taps_of(g)) coef_m[g][a] = longint'($signed(v));
  endtask

  task automatic put_sample(input int unsigned g, input logic [15:0] x, input int unsigned nt,
                            input bit cl, input int unsigned ca, input logic [16:0] cv,
                            output bit tmo);
    for (int unsigned w = 0; w < 400 && !din_ready[g]; w++) tick();
    tmo = !din_ready[g];
    if (tmo) return;
    din[g]       = x;
    ntaps[g]     = 9'(nt);
    din_valid[g] = 1'b1;
    cin[g]       = cv;
    caddr[g]     = 8'(ca);
    cload[g]     = cl;
    tick();
    din_valid[g] = 1'b0;
    cload[g]     = 1'b0;
    if (cl && int'(ca) < taps_of(g)) coef_m[g][ca] = longint'($signed(cv));
    model_push(g, x);
  endtask

  // lat = clock edges after the accepting edge until dout_valid is seen
  task automatic get_result(input int unsigned g, output int lat, output bit tmo);
    lat = 0;
    while (!dout_valid[g] && lat < 400) begin
      tick();
      lat++;
    end
    tmo = !dout_valid[g];
  endtask

  task automatic ack(input int unsigned g);
    dout_ready[g] = 1'b1;
    tick();
    dout_ready[g] = 1'b0;
  endtask

  task automatic test_reset();
    int rdy_at [3];
    rst_n = 1'b0;
    repeat (3) tick();
    for (int unsigned g = 0; g < 3; g++) begin
      vectors++;
      if (busy[g] !== 1'b1 || din_ready[g] !== 1'b0 || dout_valid[g] !== 1'b0 || dout[g] !== 16'h0000) begin
        miscompares++;
        $display("FAIL reset_values[%0d]: busy=%b din_ready=%b dout_valid=%b dout=%h, expected 1 0 0 0000",
                 g, busy[g], din_ready[g], dout_valid[g], dout[g]);
      end
    end
    model_reset();
    rst_n  = 1'b1;
    rdy_at = '{-1, -1, -1};
    for (int t = 1; t <= 300 && (rdy_at[0] < 0 || rdy_at[1] < 0 || rdy_at[2] < 0); t++) begin
      tick();
      for (int unsigned g = 0; g < 3; g++)
        if (din_ready[g] && rdy_at[g] < 0) rdy_at[g] = t;
    end
    for (int unsigned g = 0; g < 3; g++) begin
      vectors++;
      if (rdy_at[g] != taps_of(g)) begin
        miscompares++;
        $display("FAIL clear_cycles[%0d]: got %0d, expected %0d", g, rdy_at[g], taps_of(g));
      end
      vectors++;
      if (dout_valid[g] !== 1'b0 || dout[g] !== 16'h0000 || busy[g] !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_values[%0d]: dout_valid=%b dout=%h busy=%b, expected 0 0000 0",
                 g, dout_valid[g], dout[g], busy[g]);
      end
    end
  endtask

  task automatic test_impulse();
    bit t1, t2;
    int lat;
    longint e;
    for (int unsigned a = 0; a < 64; a++) load_coef(0, a, 17'(a + 1));
    for (int unsigned i = 0; i < 64; i++) begin
      put_sample(0, (i == 0) ? 16'd1 : 16'd0, 0, 1'b0, 0, 17'd0, t1);
      get_result(0, lat, t2);
      e = model_y(0, 64);
      vectors++;
      if (t1 || t2 || lat != 64) begin
        miscompares++;
        $display("FAIL impulse_latency[%0d]: got %0d edges (timeout=%0b), expected 64", i, lat, t1 | t2);
      end
      vectors++;
      if (dout[0] !== 16'(e)) begin
        miscompares++;
        $display("FAIL impulse_out[%0d]: got %0d, expected %0d", i, $signed(dout[0]), e);
      end
      ack(0);
    end
  endtask

  task automatic test_saturation();
    bit t1, t2;
    int lat;
    longint e;
    logic [15:0] rx [3];
    logic [15:0] rexp [3];
    for (int unsigned a = 0; a < 64; a++) load_coef(1, a, 17'h0FFFF);
    for (int unsigned i = 0; i < 10; i++) begin
      put_sample(1, (i < 4) ? 16'h7FFF : 16'h8000, 0, 1'b0, 0, 17'd0, t1);
      get_result(1, lat, t2);
      e = model_y(1, 64);
      vectors++;
      if (t1 || t2 || dout[1] !== 16'(e)) begin
        miscompares++;
        $display("FAIL sat_out[%0d]: got %h (timeout=%0b), expected %h", i, dout[1], t1 | t2, 16'(e));
      end
      ack(1);
    end
    load_coef(1, 0, 17'd16384);
    rx   = '{16'd3, 16'hFFFD, 16'd1};
    rexp = '{16'd2, 16'hFFFF, 16'd1};
    for (int unsigned i = 0; i < 3; i++) begin
      put_sample(1, rx[i], 1, 1'b0, 0, 17'd0, t1);
      get_result(1, lat, t2);
      vectors++;
      if (t1 || t2 || lat != 1 || dout[1] !== rexp[i]) begin
        miscompares++;
        $display("FAIL round_out[%0d]: got %h lat %0d, expected %h lat 1", i, dout[1], lat, rexp[i]);
      end
      ack(1);
    end
  endtask

  task automatic test_backpressure();
    bit t1, t2;
    int lat;
    longint e;
    for (int unsigned a = 0; a < 8; a++) load_coef(1, a, 17'(int'($urandom_range(8192)) - 4096));
    put_sample(1, 16'($urandom), 8, 1'b0, 0, 17'd0, t1);
    get_result(1, lat, t2);
    e = model_y(1, 8);
    vectors++;
    if (t1 || t2 || dout[1] !== 16'(e)) begin
      miscompares++;
      $display("FAIL bp_first: got %h (timeout=%0b), expected %h", dout[1], t1 | t2, 16'(e));
    end
    for (int unsigned c = 0; c < 10; c++) begin
      if (c == 3) begin
        cin[1] = 17'd20000; caddr[1] = 8'd5; cload[1] = 1'b1;
      end
      if (c == 5) flush[1] = 1'b1;
      if (c == 6) begin
        din[1] = 16'd123; din_valid[1] = 1'b1;
      end
      tick();
      cload[1] = 1'b0; flush[1] = 1'b0; din_valid[1] = 1'b0;
      if (c == 3) coef_m[1][5] = 20000;
      vectors++;
      if (dout_valid[1] !== 1'b1 || din_ready[1] !== 1'b0 || dout[1] !== 16'(e)) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: dout_valid=%b din_ready=%b dout=%h, expected 1 0 %h",
                 c, dout_valid[1], din_ready[1], dout[1], 16'(e));
      end
    end
    ack(1);
    vectors++;
    if (dout_valid[1] !== 1'b0 || dout[1] !== 16'(e)) begin
      miscompares++;
      $display("FAIL bp_release: dout_valid=%b dout=%h, expected 0 %h", dout_valid[1], dout[1], 16'(e));
    end
    put_sample(1, 16'($urandom), 8, 1'b0, 0, 17'd0, t1);
    get_result(1, lat, t2);
    e = model_y(1, 8);
    vectors++;
    if (t1 || t2 || dout[1] !== 16'(e)) begin
      miscompares++;
      $display("FAIL bp_new_coef: got %h (timeout=%0b), expected %h", dout[1], t1 | t2, 16'(e));
    end
    ack(1);
  endtask

  task automatic test_wrap();
    bit t1, t2;
    int lat;
    int wexp [8];
    wexp = '{1, 3, 6, 10, 15, 20, 25, 30};
    for (int unsigned a = 0; a < 5; a++) load_coef(2, a, 17'd1);
    for (int unsigned i = 0; i < 8; i++) begin
      put_sample(2, 16'(i + 1), 0, 1'b0, 0, 17'd0, t1);
      get_result(2, lat, t2);
      vectors++;
      if (t1 || t2 || lat != 5 || dout[2] !== 16'(wexp[i])) begin
        miscompares++;
        $display("FAIL wrap_out[%0d]: got %0d lat %0d, expected %0d lat 5", i, $signed(dout[2]), lat, wexp[i]);
      end
      ack(2);
    end
  endtask

  task automatic test_random();
    bit t1, t2;
    int lat;
    int n;
    int unsigned nt;
    longint e;
    for (int unsigned i = 0; i < 40; i++) begin
      if ($urandom_range(3) == 0) load_coef(2, $urandom_range(7), 17'(int'($urandom_range(200)) - 100));
      nt = $urandom_range(15);
      n  = neff(2, nt);
      put_sample(2, 16'(int'($urandom_range(200)) - 100), nt, 1'($urandom_range(1)),
                 $urandom_range(7), 17'(int'($urandom_range(200)) - 100), t1);
      get_result(2, lat, t2);
      e = model_y(2, n);
      vectors++;
      if (t1 || t2 || lat != n) begin
        miscompares++;
        $display("FAIL rand5_latency[%0d]: got %0d, expected %0d (ntaps=%0d)", i, lat, n, nt);
      end
      vectors++;
      if (dout[2] !== 16'(e)) begin
        miscompares++;
        $display("FAIL rand5_out[%0d]: got %0d, expected %0d (ntaps=%0d)", i, $signed(dout[2]), e, nt);
      end
      repeat ($urandom_range(3)) begin
        if ($urandom_range(1) == 1) load_coef(2, $urandom_range(7), 17'(int'($urandom_range(200)) - 100));
        else tick();
      end
      ack(2);
    end
    for (int unsigned a = 0; a < 64; a++) load_coef(0, a, 17'(int'($urandom_range(32)) - 16));
    for (int unsigned i = 0; i < 8; i++) begin
      nt = (i == 0) ? 64 : (i == 1) ? 65 : (i == 2) ? 1 : $urandom_range(127);
      n  = neff(0, nt);
      put_sample(0, 16'(int'($urandom_range(32)) - 16), nt, 1'b0, 0, 17'd0, t1);
      get_result(0, lat, t2);
      e = model_y(0, n);
      vectors++;
      if (t1 || t2 || lat != n || dout[0] !== 16'(e)) begin
        miscompares++;
        $display("FAIL rand64_out[%0d]: got %0d lat %0d, expected %0d lat %0d (ntaps=%0d)",
                 i, $signed(dout[0]), lat, e, n, nt);
      end
      ack(0);
    end
  endtask

  task automatic test_flush();
    bit t1, t2, saw_valid;
    int lat;
    int c;
    din[2] = 16'd99; din_valid[2] = 1'b1; flush[2] = 1'b1;
    tick();
    din_valid[2] = 1'b0; flush[2] = 1'b0;
    model_clear_hist(2);
    c = 0;
    saw_valid = 1'b0;
    while (!din_ready[2] && c < 50) begin
      if (dout_valid[2]) saw_valid = 1'b1;
      tick();
      c++;
    end
    vectors++;
    if (c != 5 || saw_valid) begin
      miscompares++;
      $display("FAIL flush_busy: got %0d busy cycles (dout_valid seen=%0b), expected 5 and 0", c, saw_valid);
    end
    for (int unsigned a = 0; a < 5; a++) load_coef(2, a, 17'd1);
    put_sample(2, 16'd7, 0, 1'b0, 0, 17'd0, t1);
    get_result(2, lat, t2);
    vectors++;
    if (t1 || t2 || dout[2] !== 16'd7) begin
      miscompares++;
      $display("FAIL flush_out: got %0d (timeout=%0b), expected 7", $signed(dout[2]), t1 | t2);
    end
    ack(2);
  endtask

  task automatic test_reset_mid();
    bit t1, t2, t3;
    int lat;
    int c;
    put_sample(0, 16'd5, 0, 1'b0, 0, 17'd0, t1);
    put_sample(1, 16'd5, 2, 1'b0, 0, 17'd0, t2);
    get_result(1, lat, t3);
    vectors++;
    if (t1 || t2 || t3 || dout_valid[1] !== 1'b1 || busy[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL rmid_setup: dout_valid1=%b busy0=%b, expected 1 1", dout_valid[1], busy[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (dout_valid !== 3'b000 || dout[1] !== 16'h0000 || busy !== 3'b111 || din_ready !== 3'b000) begin
      miscompares++;
      $display("FAIL rmid_async: dout_valid=%b dout1=%h busy=%b din_ready=%b, expected 000 0000 111 000",
               dout_valid, dout[1], busy, din_ready);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    c = 0;
    while (din_ready !== 3'b111 && c < 300) begin
      tick();
      c++;
    end
    vectors++;
    if (din_ready !== 3'b111 || dout_valid !== 3'b000) begin
      miscompares++;
      $display("FAIL rmid_recover: din_ready=%b dout_valid=%b after %0d cycles, expected 111 000",
               din_ready, dout_valid, c);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    din        = '0;
    din_valid  = '0;
    ntaps      = '0;
    cin        = '0;
    caddr      = '0;
    cload      = '0;
    flush      = '0;
    dout_ready = '0;
    tick();
    test_reset();
    test_impulse();
    test_saturation();
    test_backpressure();
    test_wrap();
    test_random();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
